// File: rtl/note_detect.sv
// note_detect: groups FFT magnitude writes into frames, picks the loudest tracked note bin per
// frame and debounces it into a stable note number.
//   clock_27mhz  in   1   system clock
//   reset_n      in   1   asynchronous active-low reset
//   haddr        in   12  FFT bin index of current magnitude
//   hdata        in   10  magnitude, unsigned
//   hwe          in   1   write strobe; haddr/hdata valid only when high
//   note_out     out  4   debounced note index, 4'hF = silence
//   note_valid   out  1   one-cycle pulse when note_out changes
//   peak_mag     out  10  best magnitude of the last closed frame
//   frame_strobe out  1   one-cycle pulse, one cycle after each frame close
module note_detect #(
   parameter int                   NNOTES        = 8,
   parameter logic [12*NNOTES-1:0] NOTE_BINS     = {12'h012, 12'h011, 12'h010, 12'h00F,
                                                    12'h00E, 12'h00D, 12'h00C, 12'h00B},
   parameter logic [9:0]           THRESH        = 10'd64,
   parameter logic [19:0]          FRAME_GAP     = 20'd100000,
   parameter logic [2:0]           STABLE_FRAMES = 3'd3
) (
   input  logic        clock_27mhz,
   input  logic        reset_n,
   input  logic [11:0] haddr,
   input  logic [9:0]  hdata,
   input  logic        hwe,
   output logic [3:0]  note_out,
   output logic        note_valid,
   output logic [9:0]  peak_mag,
   output logic        frame_strobe
);
   typedef enum logic {IDLE, ACCUM} state_t;
   localparam logic [3:0]  SILENCE  = 4'hF;
   localparam logic [19:0] GAP_LAST = FRAME_GAP - 20'd1;
   state_t              state;
   logic [NNOTES-1:0]   seen;
   logic [3:0]          best_idx;
   logic [9:0]          best_mag;
   logic [19:0]         idle;
   logic [3:0]          cand;
   logic [3:0]          prev_cand;
   logic [2:0]          stable;
   logic                hit;
   logic [3:0]          idx;
   logic [NNOTES-1:0]   oh;
   logic                rep;
   logic                close_b;
   logic                close;
   logic                better;
   logic [2:0]          stable_nx;
   // descending scan so the lowest matching note index wins on duplicate bins
   always_comb begin
      hit = 1'b0;
      idx = 4'd0;
      oh  = '0;
      for (int i = NNOTES - 1; i >= 0; i--)
         if (hwe && haddr == NOTE_BINS[12*i +: 12]) begin
            hit   = 1'b1;
            idx   = 4'(i);
            oh    = '0;
            oh[i] = 1'b1;
         end
      rep       = hit && |(seen & oh);
      close_b   = state == ACCUM && !hit && idle == GAP_LAST;
      close     = (state == ACCUM && rep) || close_b;
      better    = hdata > best_mag || (hdata == best_mag && idx < best_idx);
      stable_nx = (cand == prev_cand) ? ((stable == 3'd7) ? 3'd7 : stable + 3'd1) : 3'd1;
   end
   always_ff @(posedge clock_27mhz or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         seen         <= '0;
         best_idx     <= SILENCE;
         best_mag     <= '0;
         idle         <= '0;
         cand         <= SILENCE;
         prev_cand    <= SILENCE;
         stable       <= '0;
         note_out     <= SILENCE;
         note_valid   <= 1'b0;
         peak_mag     <= '0;
         frame_strobe <= 1'b0;
      end else begin
         frame_strobe <= close;
         note_valid   <= 1'b0;
         if (close) begin
            peak_mag <= best_mag;
            cand     <= (best_mag < THRESH) ? SILENCE : best_idx;
         end
         // debounce stage runs on the cycle after a close, from the snapshot taken at close
         if (frame_strobe) begin
            stable    <= stable_nx;
            prev_cand <= cand;
            if (stable_nx >= STABLE_FRAMES && cand != note_out) begin
               note_out   <= cand;
               note_valid <= 1'b1;
            end
         end
         // a repeated bin marks the next FFT frame: close and restart in the same cycle
         if (hit && (state == IDLE || rep)) begin
            state    <= ACCUM;
            seen     <= oh;
            best_idx <= idx;
            best_mag <= hdata;
            idle     <= '0;
         end else if (hit) begin
            seen <= seen | oh;
            idle <= '0;
            if (better) begin
               best_idx <= idx;
               best_mag <= hdata;
            end
         end else if (close_b) begin
            state <= IDLE;
            seen  <= '0;
            idle  <= '0;
         end else if (state == ACCUM && idle != GAP_LAST)
            idle <= idle + 20'd1;
      end
   end
endmodule

// File: tb/tb_note_detect.sv
// tb_note_detect: directed checks of framing, peak pick, threshold, debounce and reset.
module tb_note_detect;
   logic        clock_27mhz = 1'b0;
   logic        reset_n = 1'b0;
   logic [11:0] haddr = '0;
   logic [9:0]  hdata = '0;
   logic        hwe = 1'b0;
   logic [3:0]  note_out;
   logic        note_valid;
   logic [9:0]  peak_mag;
   logic        frame_strobe;
   int vectors = 0;
   int miscompares = 0;
   int fs_cnt = 0;
   int nv_cnt = 0;
   int f0;
   int n0;
   note_detect #(.FRAME_GAP(20'd16)) dut (
      .clock_27mhz(clock_27mhz),
      .reset_n(reset_n),
      .haddr(haddr),
      .hdata(hdata),
      .hwe(hwe),
      .note_out(note_out),
      .note_valid(note_valid),
      .peak_mag(peak_mag),
      .frame_strobe(frame_strobe)
   );
   always #5 clock_27mhz = ~clock_27mhz;
   always @(negedge clock_27mhz)
      if (reset_n) begin
         if (frame_strobe) fs_cnt <= fs_cnt + 1;
         if (note_valid) nv_cnt <= nv_cnt + 1;
      end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic wr(input logic [11:0] a, input logic [9:0] d);
      @(negedge clock_27mhz);
      haddr = a;
      hdata = d;
      hwe = 1'b1;
      @(negedge clock_27mhz);
      hwe = 1'b0;
   endtask
   task automatic idle(input int n);
      repeat (n) @(negedge clock_27mhz);
   endtask
   task automatic wait_fs(input string tag);
      int n;
      n = 0;
      while (frame_strobe !== 1'b1 && n < 40) begin
         @(negedge clock_27mhz);
         n++;
      end
      chk(tag, 32'(n < 40), 32'd1);
   endtask
   initial begin
      idle(3);
      chk("rst_note_out", 32'(note_out), 32'hF);
      chk("rst_note_valid", 32'(note_valid), 32'd0);
      chk("rst_peak_mag", 32'(peak_mag), 32'd0);
      chk("rst_frame_strobe", 32'(frame_strobe), 32'd0);
      reset_n = 1'b1;
      // single frame closed by timeout
      f0 = fs_cnt;
      wr(12'h00B, 10'd50);
      wr(12'h00D, 10'd200);
      wr(12'h00F, 10'd120);
      wait_fs("t2_close");
      chk("t2_peak", 32'(peak_mag), 32'd200);
      chk("t2_cand", 32'(dut.cand), 32'd2);
      idle(4);
      chk("t2_fs_count", 32'(fs_cnt - f0), 32'd1);
      chk("t2_note_out", 32'(note_out), 32'hF);
      chk("t2_nv_count", 32'(nv_cnt), 32'd0);
      // three repeat-closed frames with note 3 as peak
      wr(12'h00E, 10'd300);
      wr(12'h00B, 10'd20);
      wr(12'h00E, 10'd300);
      chk("t3_f1_fs", 32'(frame_strobe), 32'd1);
      chk("t3_f1_peak", 32'(peak_mag), 32'd300);
      wr(12'h00B, 10'd20);
      wr(12'h00E, 10'd300);
      chk("t3_f2_fs", 32'(frame_strobe), 32'd1);
      chk("t3_f2_nv", 32'(note_valid), 32'd0);
      wr(12'h00B, 10'd20);
      wr(12'h00E, 10'd300);
      chk("t3_f3_fs", 32'(frame_strobe), 32'd1);
      chk("t3_f3_nv_early", 32'(note_valid), 32'd0);
      @(negedge clock_27mhz);
      chk("t3_nv_pulse", 32'(note_valid), 32'd1);
      chk("t3_note_out", 32'(note_out), 32'd3);
      @(negedge clock_27mhz);
      chk("t3_nv_end", 32'(note_valid), 32'd0);
      n0 = nv_cnt;
      wr(12'h00B, 10'd20);
      wait_fs("t3_f4_close");
      chk("t3_f4_peak", 32'(peak_mag), 32'd300);
      idle(4);
      chk("t3_f4_no_pulse", 32'(nv_cnt - n0), 32'd0);
      chk("t3_f4_note_out", 32'(note_out), 32'd3);
      // tie resolves to lower index; threshold boundary
      wr(12'h010, 10'd90);
      wr(12'h00C, 10'd90);
      wait_fs("t4_tie_close");
      chk("t4_tie_peak", 32'(peak_mag), 32'd90);
      chk("t4_tie_cand", 32'(dut.cand), 32'd1);
      wr(12'h00B, 10'd63);
      wr(12'h012, 10'd10);
      wait_fs("t4_low_close");
      chk("t4_low_peak", 32'(peak_mag), 32'd63);
      chk("t4_low_cand", 32'(dut.cand), 32'hF);
      wr(12'h011, 10'd64);
      wait_fs("t4_thr_close");
      chk("t4_thr_peak", 32'(peak_mag), 32'd64);
      chk("t4_thr_cand", 32'(dut.cand), 32'd6);
      // foreign bins ignored, and do not hold off the timeout
      idle(2);
      f0 = fs_cnt;
      wr(12'h011, 10'd100);
      wr(12'h02A, 10'd1023);
      wr(12'h00F, 10'd40);
      for (int i = 0; i < 15; i++) wr(12'h02A, 10'd1023);
      idle(2);
      chk("t5_fs_count", 32'(fs_cnt - f0), 32'd1);
      chk("t5_peak", 32'(peak_mag), 32'd100);
      chk("t5_cand", 32'(dut.cand), 32'd6);
      for (int i = 0; i < 15; i++) wr(12'h02A, 10'd1023);
      idle(2);
      chk("t5_idle_foreign", 32'(fs_cnt - f0), 32'd1);
      // repeat close restarts the frame from the repeating write
      wr(12'h00B, 10'd10);
      wr(12'h00C, 10'd400);
      wr(12'h00B, 10'd500);
      chk("t6_fs", 32'(frame_strobe), 32'd1);
      chk("t6_peak", 32'(peak_mag), 32'd400);
      chk("t6_cand", 32'(dut.cand), 32'd1);
      chk("t6_new_best_mag", 32'(dut.best_mag), 32'd500);
      chk("t6_new_best_idx", 32'(dut.best_idx), 32'd0);
      @(negedge clock_27mhz);
      wait_fs("t6_f2_close");
      chk("t6_f2_peak", 32'(peak_mag), 32'd500);
      chk("t6_f2_cand", 32'(dut.cand), 32'd0);
      chk("t6_note_out", 32'(note_out), 32'd3);
      // asynchronous reset mid-frame
      wr(12'h00C, 10'd200);
      #2 reset_n = 1'b0;
      #1;
      chk("t1_note_out", 32'(note_out), 32'hF);
      chk("t1_note_valid", 32'(note_valid), 32'd0);
      chk("t1_peak_mag", 32'(peak_mag), 32'd0);
      chk("t1_frame_strobe", 32'(frame_strobe), 32'd0);
      @(negedge clock_27mhz);
      reset_n = 1'b1;
      f0 = fs_cnt;
      idle(40);
      chk("t1_no_close", 32'(fs_cnt - f0), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
